// File: rtl/pipelined_adder.sv
// Segmented ripple adder: STAGES register slices, each adding one SEG-bit slice
// with the carry from the slice before, under a single stall-everything enable.
`timescale 1ns/1ps

module pipelined_adder_seg #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             p_vld,
  input  logic [WIDTH-1:0] p_a,
  input  logic [WIDTH-1:0] p_b,
  input  logic [WIDTH-1:0] p_sum,
  input  logic             p_c,
  input  logic             p_ma,
  input  logic             p_mb,
  output logic             q_vld,
  output logic [WIDTH-1:0] q_a,
  output logic [WIDTH-1:0] q_b,
  output logic [WIDTH-1:0] q_sum,
  output logic             q_c,
  output logic             q_ma,
  output logic             q_mb
);
  localparam int HI = (K + 1) * SEG;

  logic [SEG:0]       seg_sum;
  logic [WIDTH-1:0]   seg_pos;
  logic [WIDTH-1:0]   up_mask;

  // Slices below HI are consumed here, so only the upper operand bits travel on.
  always_comb begin
    seg_sum = {1'b0, p_a[K*SEG +: SEG]} + {1'b0, p_b[K*SEG +: SEG]} + {{SEG{1'b0}}, p_c};
    seg_pos = '0;
    seg_pos[K*SEG +: SEG] = seg_sum[SEG-1:0];
    for (int i = 0; i < WIDTH; i++) up_mask[i] = (i >= HI);
  end

  // Upstream only ever fills slices below K, so OR-ing in this slice is exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld <= 1'b0;
      q_a   <= '0;
      q_b   <= '0;
      q_sum <= '0;
      q_c   <= 1'b0;
      q_ma  <= 1'b0;
      q_mb  <= 1'b0;
    end else if (en) begin
      q_vld <= p_vld;
      q_a   <= p_a & up_mask;
      q_b   <= p_b & up_mask;
      q_sum <= p_sum | seg_pos;
      q_c   <= seg_sum[SEG];
      q_ma  <= p_ma;
      q_mb  <= p_mb;
    end
  end
endmodule

module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SEG = WIDTH / STAGES;

  logic                         en;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][WIDTH-1:0]   a_pipe;
  logic [STAGES:0][WIDTH-1:0]   b_pipe;
  logic [STAGES:0][WIDTH-1:0]   sum_pipe;
  logic [STAGES:0]              c_pipe;
  logic [STAGES:0]              ma_pipe;
  logic [STAGES:0]              mb_pipe;
  logic                         unused_skew;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Bubbles enter as all-zero data so nothing from an idle bus is ever captured.
  assign vld_pipe[0] = in_valid;
  assign a_pipe[0]   = in_valid ? a : '0;
  assign b_pipe[0]   = in_valid ? b : '0;
  assign sum_pipe[0] = '0;
  assign c_pipe[0]   = in_valid & cin;
  assign ma_pipe[0]  = a_pipe[0][WIDTH-1];
  assign mb_pipe[0]  = b_pipe[0][WIDTH-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipelined_adder_seg #(.WIDTH(WIDTH), .SEG(SEG), .K(k)) u_seg (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .p_vld (vld_pipe[k]),
      .p_a   (a_pipe[k]),
      .p_b   (b_pipe[k]),
      .p_sum (sum_pipe[k]),
      .p_c   (c_pipe[k]),
      .p_ma  (ma_pipe[k]),
      .p_mb  (mb_pipe[k]),
      .q_vld (vld_pipe[k+1]),
      .q_a   (a_pipe[k+1]),
      .q_b   (b_pipe[k+1]),
      .q_sum (sum_pipe[k+1]),
      .q_c   (c_pipe[k+1]),
      .q_ma  (ma_pipe[k+1]),
      .q_mb  (mb_pipe[k+1])
    );
  end

  // The last slice's operand copy is always zero; nothing downstream needs it.
  assign unused_skew = ^{a_pipe[STAGES], b_pipe[STAGES]};

  assign out_valid = vld_pipe[STAGES];
  assign sum       = sum_pipe[STAGES];
  assign cout      = c_pipe[STAGES];
  assign ovf       = (ma_pipe[STAGES] == mb_pipe[STAGES]) && (sum[WIDTH-1] != ma_pipe[STAGES]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed checks for pipelined_adder (WIDTH=16, STAGES=4): arithmetic corners,
// latency, bubbles, backpressure stall and mid-flight reset.
`timescale 1ns/1ps

module tb_pipelined_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int passed = 0;
  int total  = 0;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic drive_one(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; cin = cv;
    @(negedge clk);
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (sum !== 16'h0000) $display("FAIL reset_sum got %h want 0000", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_carry;
    int lat;
    drive_one(16'hFFFF, 16'h0001, 1'b0);
    wait_out(lat);
    total++; if (lat !== 4) $display("FAIL carry_latency got %0d want 4", lat); else passed++;
    total++; if (sum !== 16'h0000) $display("FAIL carry_sum got %h want 0000", sum); else passed++;
    total++; if (cout !== 1'b1) $display("FAIL carry_cout got %b want 1", cout); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL carry_ovf got %b want 0", ovf); else passed++;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    int lat;
    drive_one(16'h7FFF, 16'h0001, 1'b0);
    wait_out(lat);
    total++; if (lat !== 4) $display("FAIL ovf_pos_latency got %0d want 4", lat); else passed++;
    total++; if (sum !== 16'h8000) $display("FAIL ovf_pos_sum got %h want 8000", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL ovf_pos_cout got %b want 0", cout); else passed++;
    total++; if (ovf !== 1'b1) $display("FAIL ovf_pos_ovf got %b want 1", ovf); else passed++;
    @(negedge clk);
    drive_one(16'h8000, 16'h8000, 1'b0);
    wait_out(lat);
    total++; if (lat !== 4) $display("FAIL ovf_neg_latency got %0d want 4", lat); else passed++;
    total++; if (sum !== 16'h0000) $display("FAIL ovf_neg_sum got %h want 0000", sum); else passed++;
    total++; if (cout !== 1'b1) $display("FAIL ovf_neg_cout got %b want 1", cout); else passed++;
    total++; if (ovf !== 1'b1) $display("FAIL ovf_neg_ovf got %b want 1", ovf); else passed++;
    @(negedge clk);
  endtask

  task automatic test_cin;
    int lat;
    drive_one(16'h1234, 16'h4321, 1'b1);
    wait_out(lat);
    total++; if (lat !== 4) $display("FAIL cin_latency got %0d want 4", lat); else passed++;
    total++; if (sum !== 16'h5556) $display("FAIL cin_sum got %h want 5556", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL cin_cout got %b want 0", cout); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL cin_ovf got %b want 0", ovf); else passed++;
    @(negedge clk);
  endtask

  task automatic test_bubbles;
    logic pat [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        total++;
        if (out_valid !== pat[c-4]) $display("FAIL bubble_valid cyc %0d got %b want %b", c, out_valid, pat[c-4]);
        else passed++;
        if (pat[c-4]) begin
          total++;
          if (sum !== 16'(c - 3)) $display("FAIL bubble_sum cyc %0d got %h want %h", c, sum, 16'(c - 3));
          else passed++;
        end
      end
      in_valid = (c < 6) ? pat[c] : 1'b0;
      a = 16'(c); b = 16'h0001; cin = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] va [8] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h4000, 16'h00FF, 16'hABCD, 16'h0FFF, 16'h5555};
    logic [15:0] vb [8] = '{16'h0002, 16'hFFFF, 16'hFFFF, 16'h4000, 16'h0F01, 16'h1111, 16'h0000, 16'hAAAA};
    logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] es [8] = '{16'h0003, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h1000, 16'hBCDF, 16'h1000, 16'h0000};
    logic        ec [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        eo [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int ni = 0;
    int no = 0;
    int cyc = 0;
    while (no < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc <= 9);
      if (ni < 8) begin
        in_valid = 1'b1; a = va[ni]; b = vb[ni]; cin = vc[ni];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 5 && cyc <= 9) begin
        total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready cyc %0d got %b want 0", cyc, in_ready); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL stall_out_valid cyc %0d got %b want 1", cyc, out_valid); else passed++;
        total++; if (sum !== es[no]) $display("FAIL stall_hold_sum cyc %0d got %h want %h", cyc, sum, es[no]); else passed++;
      end
      if (out_valid && out_ready) begin
        total++; if (sum !== es[no]) $display("FAIL b2b_sum #%0d got %h want %h", no, sum, es[no]); else passed++;
        total++; if (cout !== ec[no]) $display("FAIL b2b_cout #%0d got %b want %b", no, cout, ec[no]); else passed++;
        total++; if (ovf !== eo[no]) $display("FAIL b2b_ovf #%0d got %b want %b", no, ovf, eo[no]); else passed++;
        no++;
      end
      if (in_valid && in_ready) ni++;
      cyc++;
    end
    total++; if (no !== 8) $display("FAIL b2b_count got %0d want 8", no); else passed++;
    total++; if (cyc !== 17) $display("FAIL b2b_cycles got %0d want 17", cyc); else passed++;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_flush;
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h1111 * 16'(i + 1); b = 16'h0101; cin = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", in_ready); else passed++;
    total++; if (sum !== 16'h0000) $display("FAIL flush_sum got %h want 0000", sum); else passed++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) $display("FAIL flush_leak got %0d want 0", seen); else passed++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    test_reset;
    test_carry;
    test_overflow;
    test_cin;
    test_bubbles;
    test_back_to_back;
    test_reset_flush;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4: number of pipeline segments; WIDTH SHALL be an integer multiple of STAGES, and SEG = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  a, b and cin carry a transaction.
REQ-006 in_ready  output  1  pipeline accepts a transaction this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned or two's-complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  sum, cout and ovf hold a result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed overflow: operand MSBs equal and sum MSB differs.

Function
REQ-015 SHALL split the add into STAGES segments; stage k adds bits [k*SEG +: SEG] with the carry registered from stage k-1, and stage 0 uses cin.
REQ-016 SHALL register the not-yet-consumed upper operand segments (skew) and the already-computed lower sum segments (deskew) per stage, so that all result bits of one transaction leave together.
REQ-017 each stage SHALL carry a valid bit; the last stage's valid drives out_valid.
REQ-018 global advance enable SHALL be en = !out_valid || out_ready.
REQ-019 in_ready SHALL equal en, purely combinationally; a transaction is accepted when in_valid && in_ready.
REQ-020 when en=1, every stage register SHALL shift one stage forward, and stage-0 valid SHALL load in_valid.
REQ-021 when en=0, all stage registers SHALL hold (full stall); sum, cout and ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 latency SHALL be exactly STAGES cycles from acceptance to out_valid with no stall; throughput SHALL be 1 transaction per cycle.
REQ-023 bubbles (in_valid=0 while en=1) SHALL propagate as invalid stages; the pipeline SHALL NOT collapse them.
REQ-024 results SHALL emerge in acceptance order; none SHALL be dropped or duplicated under any out_ready pattern.
REQ-025 STAGES=1 SHALL degenerate to a single registered adder with latency 1.
REQ-026 SHALL compute ovf from registered operand MSBs travelling with the transaction, not from live inputs.
REQ-027 a and b SHALL be ignored when in_valid=0.

Reset
REQ-028 on a clk edge with rst=1, all stage valid bits SHALL clear to 0, so out_valid=0 on the next cycle.
REQ-029 after reset, sum, cout and ovf SHALL read 0; data registers SHALL clear to 0.
REQ-030 rst SHALL override en; transactions in flight during rst are discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts, since out_valid=0.

Verification (WIDTH=16, STAGES=4, out_ready=1 unless stated)
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> 4 cycles later: sum=0x0000, cout=1, ovf=0.
REQ-033 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-034 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
REQ-035 back-to-back 8 random transactions, then out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, outputs held, all 8 results in order versus a reference model (a+b+cin).
REQ-036 accept 3 transactions, then rst=1 for 1 cycle -> out_valid=0 next cycle, none of the 3 results ever appear, and in_ready=1.
REQ-037 alternating in_valid 1/0 -> out_valid alternates with the same bubble pattern, with latency 4.
